// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the 8N1 UART receiver and transmitter.
//   uart_state_t    - receiver frame states
//   UART_DATA_BITS  - data bits per frame
//   half_bit_reload - baud counter load value that lands on the middle of a bit
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } uart_state_t;

    localparam int UART_DATA_BITS = 8;

    // The counter reaches 0 after (reload + 1) edges, so loading half-1 puts
    // the first sample exactly half a bit after the start edge.
    function automatic int half_bit_reload(input int clks);
        return clks / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchronizer for an asynchronous single-bit input.
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, presets both flops to RST_VAL
//   d     - asynchronous input
//   q     - synchronized output
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// uart_rx_8n1: 8N1 UART receiver with mid-bit sampling and framing-error detection.
//   clk     - system clock, rising edge
//   rst_n   - asynchronous active-low reset
//   rx      - asynchronous serial line, idles high
//   rxbyte  - last correctly received byte, held between frames
//   rxvalid - one-cycle pulse when rxbyte is updated
//   rxerror - one-cycle pulse when the stop bit was sampled low
//   rxbusy  - high while a frame is in progress
module uart_rx_8n1
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rxbyte,
    output logic       rxvalid,
    output logic       rxerror,
    output logic       rxbusy
);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535) begin : g_bad_clks_per_bit
        $error("uart_rx_8n1: CLKS_PER_BIT must be within 4..65535");
    end

    localparam int            CW   = $clog2(CLKS_PER_BIT);
    localparam int            BW   = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(half_bit_reload(CLKS_PER_BIT));
    localparam logic [BW-1:0] LAST = BW'(UART_DATA_BITS - 1);

    uart_state_t               state, state_d;
    logic [CW-1:0]             cnt, cnt_d;
    logic [BW-1:0]             bit_cnt, bit_d;
    logic [UART_DATA_BITS-1:0] shift, shift_d;
    logic                      rx_s, active, tick;
    logic                      valid_d, error_d, pend_valid, pend_error;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    assign active = state inside {START, DATA, STOP};
    assign tick   = active && cnt == '0;
    assign rxbusy = state != IDLE;

    always_comb begin
        state_d = state;
        cnt_d   = tick ? FULL : active ? cnt - CW'(1) : cnt;
        bit_d   = bit_cnt;
        shift_d = shift;
        valid_d = 1'b0;
        error_d = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    cnt_d   = HALF;
                    state_d = START;
                end
            end
            START: begin
                if (tick) begin
                    state_d = rx_s ? IDLE : DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    shift_d = {rx_s, shift[UART_DATA_BITS-1:1]};
                    bit_d   = bit_cnt + 1'b1;
                    state_d = bit_cnt == LAST ? STOP : DATA;
                end
            end
            STOP: begin
                // Leaving at the stop sample (mid stop bit) re-arms start
                // detection half a bit early for back-to-back frames.
                if (tick) begin
                    valid_d = rx_s;
                    error_d = !rx_s;
                    state_d = rx_s ? IDLE : WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            pend_valid <= 1'b0;
            pend_error <= 1'b0;
            rxvalid    <= 1'b0;
            rxerror    <= 1'b0;
            rxbyte     <= '0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            bit_cnt    <= bit_d;
            shift      <= shift_d;
            // Strobes are presented one edge after the stop sample.
            pend_valid <= valid_d;
            pend_error <= error_d;
            rxvalid    <= pend_valid;
            rxerror    <= pend_error;
            if (pend_valid) rxbyte <= shift;
        end
    end

endmodule

// File: tb/tb_uart_rx_8n1.sv
// tb_uart_rx_8n1: self-checking bench for uart_rx_8n1 at CLKS_PER_BIT 16 and 4.
module tb_uart_rx_8n1;

    localparam int C16 = 16;
    localparam int C4  = 4;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] data;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rx16 = 1'b1;
    logic       rx4 = 1'b1;
    logic [7:0] byte16, byte4;
    logic       v16, v4, e16, e4, b16, b4;

    int         cyc = 0;
    int         npass = 0;
    int         ntot = 0;
    ev_t        q16[$], q4[$], log16[$], log4[$];
    logic [7:0] mb16 = 8'h00;
    logic [7:0] mb4 = 8'h00;

    uart_rx_8n1 #(.CLKS_PER_BIT(C16)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx(rx16),
        .rxbyte(byte16), .rxvalid(v16), .rxerror(e16), .rxbusy(b16)
    );

    uart_rx_8n1 #(.CLKS_PER_BIT(C4)) dut4 (
        .clk(clk), .rst_n(rst_n), .rx(rx4),
        .rxbyte(byte4), .rxvalid(v4), .rxerror(e4), .rxbusy(b4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Expected strobes come from the frame list: a frame whose line falls
    // after cycle F produces its strobe on edge F + 2 (sync) + 1 (start seen)
    // + C/2 + 9*C + 1.
    task automatic cmp(input int d, input logic v, input logic e, input logic [7:0] b);
        ev_t hd;
        ev_t lg;
        bit  hit = 1'b0;
        if (d == 0 && q16.size() > 0 && q16[0].cyc <= cyc) begin
            hd  = q16.pop_front();
            hit = 1'b1;
        end
        if (d == 1 && q4.size() > 0 && q4[0].cyc <= cyc) begin
            hd  = q4.pop_front();
            hit = 1'b1;
        end
        hit = hit && hd.cyc == cyc;
        if (hit && !hd.err) begin
            if (d == 0) mb16 = hd.data;
            else mb4 = hd.data;
        end
        chk(d == 0 ? "rxvalid16" : "rxvalid4", v, hit && !hd.err);
        chk(d == 0 ? "rxerror16" : "rxerror4", e, hit && hd.err);
        chk(d == 0 ? "rxbyte16" : "rxbyte4", b, d == 0 ? mb16 : mb4);
        if (v || e) begin
            lg.cyc  = cyc;
            lg.err  = e;
            lg.data = b;
            if (d == 0) log16.push_back(lg);
            else log4.push_back(lg);
        end
    endtask

    always @(posedge clk) begin
        #1;
        cmp(0, v16, e16, byte16);
        cmp(1, v4, e4, byte4);
    end

    task automatic set_rx(input int d, input logic v);
        if (d == 0) rx16 = v;
        else rx4 = v;
    endtask

    task automatic send(input int d, input logic [7:0] b, input logic stop, output int fall);
        int         c = d == 0 ? C16 : C4;
        logic [9:0] fr = {stop, b, 1'b0};
        ev_t        ev;
        fall    = cyc;
        ev.cyc  = fall + 2 + 1 + c / 2 + 9 * c + 1;
        ev.err  = !stop;
        ev.data = b;
        if (d == 0) q16.push_back(ev);
        else q4.push_back(ev);
        for (int k = 0; k < 10; k++) begin
            set_rx(d, fr[k]);
            repeat (c) @(negedge clk);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int f, n0, nerr;
        #1 rst_n = 1'b0;
        #1;
        chk("reset_byte16", byte16, 8'h00);
        chk("reset_valid16", v16, 1'b0);
        chk("reset_error16", e16, 1'b0);
        chk("reset_busy16", b16, 1'b0);
        chk("reset_byte4", byte4, 8'h00);
        chk("reset_valid4", v4, 1'b0);
        chk("reset_error4", e4, 1'b0);
        chk("reset_busy4", b4, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        n0 = log16.size();
        send(0, 8'hA5, 1'b1, f);
        repeat (20) @(negedge clk);
        chk("a5_count", log16.size() - n0, 1);
        chk("a5_cycle", log16.size() > n0 ? log16[n0].cyc : -1, f + 156);
        chk("a5_byte", byte16, 8'hA5);

        n0 = log16.size();
        f  = cyc;
        rx16 = 1'b0;
        repeat (4) @(negedge clk);
        rx16 = 1'b1;
        @(negedge clk);
        chk("glitch_busy_rise", b16, 1'b1);
        repeat (7) @(negedge clk);
        chk("glitch_busy_fall", b16, 1'b0);
        repeat (20) @(negedge clk);
        chk("glitch_count", log16.size() - n0, 0);
        chk("glitch_byte", byte16, 8'hA5);

        n0 = log16.size();
        send(0, 8'h3C, 1'b0, f);
        repeat (40) @(negedge clk);
        chk("break_busy_held", b16, 1'b1);
        rx16 = 1'b1;
        repeat (4) @(negedge clk);
        chk("break_busy_released", b16, 1'b0);
        chk("break_count", log16.size() - n0, 1);
        chk("break_is_error", log16.size() > n0 ? log16[n0].err : 1'b0, 1'b1);
        chk("break_byte", byte16, 8'hA5);
        repeat (16) @(negedge clk);
        send(0, 8'h81, 1'b1, f);
        repeat (20) @(negedge clk);
        chk("after_break_byte", byte16, 8'h81);

        n0 = log16.size();
        send(0, 8'h00, 1'b1, f);
        send(0, 8'hFF, 1'b1, f);
        repeat (20) @(negedge clk);
        chk("b2b_count", log16.size() - n0, 2);
        chk("b2b_spacing", log16.size() > n0 + 1 ? log16[n0+1].cyc - log16[n0].cyc : -1, 10 * C16);
        chk("b2b_first", log16.size() > n0 ? log16[n0].data : 8'hXX, 8'h00);
        chk("b2b_second", log16.size() > n0 + 1 ? log16[n0+1].data : 8'hXX, 8'hFF);

        n0 = log16.size();
        fork
            send(0, 8'hF0, 1'b1, f);
            begin
                repeat (5 * C16 + 4) @(negedge clk);
                #2 rst_n = 1'b0;
                q16.delete();
                q4.delete();
                mb16 = 8'h00;
                mb4  = 8'h00;
                #1;
                chk("rst_async_byte", byte16, 8'h00);
                chk("rst_async_busy", b16, 1'b0);
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
            end
        join
        repeat (20) @(negedge clk);
        chk("rst_abort_count", log16.size() - n0, 0);
        send(0, 8'h5A, 1'b1, f);
        repeat (20) @(negedge clk);
        chk("after_rst_byte", byte16, 8'h5A);

        n0 = log4.size();
        for (int i = 0; i < 256; i++) send(1, 8'($urandom), 1'b1, f);
        repeat (20) @(negedge clk);
        chk("stream_count", log4.size() - n0, 256);
        nerr = 0;
        foreach (log4[i]) nerr += int'(log4[i].err);
        chk("stream_errors", nerr, 0);
        chk("q16_drained", q16.size(), 0);
        chk("q4_drained", q4.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule

// File: doc/uart_rx_8n1.md
Name: uart_rx_8n1

Overview:
- 8N1 UART receiver: the receive end of the team's transmit-only 8N1 UART.
- Samples an asynchronous serial line, detects and validates the start bit, and shifts in 8 data bits LSB first.
- Checks the stop bit, then presents the byte with a one-cycle valid strobe. A framing error produces an error strobe instead.
- Sits between the board RX pin and byte-level consumers (command parser, loopback test logic).

Parameters:
- CLKS_PER_BIT, 16: clk cycles per serial bit period. Legal range is 4 to 65535; an out-of-range value must fail elaboration.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  active-low reset.
- rx  input  1  serial line, asynchronous to clk; idles high.
- rxbyte  output  8  last correctly received byte; held between frames.
- rxvalid  output  1  one-cycle pulse: rxbyte updated this cycle.
- rxerror  output  1  one-cycle pulse: framing error (stop bit sampled low).
- rxbusy  output  1  high while a frame is in progress (any state other than IDLE).

Interface (already decided):
- One clock (clk). Reset rst_n is asynchronous and active-low.
- No other clock domains; rx is the only asynchronous input.

Behaviour:
- Reset, applied asynchronously:
  - rxbyte=0x00, rxvalid=0, rxerror=0, rxbusy=0.
  - State=IDLE, bit and baud counters=0.
  - Both synchronizer flops preset to 1, so the idle line is not mistaken for a start bit after reset.
- Reset mid-frame aborts the frame silently: no rxvalid, no rxerror.
- Synchronizer: rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- Timing reference: t0 is the clk edge on which the FSM is in IDLE and samples rx_s==0. Sample points are:
  - t0 + CLKS_PER_BIT/2 + k*CLKS_PER_BIT, with integer division.
  - k=0 is the start bit, k=1..8 are data bits d0..d7, k=9 is the stop bit.
- States:
  - IDLE: rxbusy=0. On rx_s==0, load the baud counter for a half bit and go to START.
  - START: at sample k=0, if rx_s==0 go to DATA. If rx_s==1 it was a glitch: return to IDLE with no strobe.
  - DATA: at each sample, shift rx_s into the MSB of the shift register (right shift), which assembles the byte LSB first. After the 8th data sample go to STOP.
  - STOP, stop sample rx_s==1: on the next edge, rxbyte<=shift register, rxvalid=1 for exactly 1 cycle, go to IDLE. IDLE is re-entered half a bit early so that a back-to-back start edge is caught.
  - STOP, stop sample rx_s==0: rxerror=1 for exactly 1 cycle, rxbyte unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rx_s==1, then IDLE. This handles a break condition: no new frame starts while the line is held low.
- Latency: rxvalid/rxerror assert 1 cycle after the stop sample edge. Measured from the rx pin falling edge, that is 2 sync cycles + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles, ±1 for pin-to-clk phase.
- rxvalid and rxerror are never high in the same cycle. The consumer must capture on the rxvalid pulse; there is no backpressure and no overrun flag.
- Baud counter width: clog2(CLKS_PER_BIT). It decrements and reloads CLKS_PER_BIT-1 on reaching 0; it never wraps outside that range.
- Bit counter: 0..7 in DATA, reset on entering DATA.

Decomposition:
- Package uart_pkg holds:
  - the state enum (IDLE, START, DATA, STOP, WAIT_HIGH);
  - UART_DATA_BITS=8;
  - the function computing the half-bit reload value.
  - The package is shared with the transmitter.
- Sub-module uart_sync2: a 2-flop synchronizer with a reset value parameter. It is reusable for other async pins.

Test Plan:
- CLKS_PER_BIT=16, send 0xA5 (rx line low, then 1,0,1,0,0,1,0,1, then high) -> exactly one rxvalid pulse, rxbyte=0xA5, rxerror never high, pulse in the cycle predicted by the latency formula.
- Glitch: rx low for 4 cycles, then high -> rxbusy rises, then returns to IDLE by the start sample; no rxvalid, no rxerror; rxbyte keeps its previous value.
- Frame 0x3C with the stop bit driven low, line held low for a further 40 cycles, then high -> one rxerror pulse, no rxvalid, rxbyte unchanged, rxbusy stays high until the line goes high. A following frame 0x81 is received correctly.
- Back-to-back frames 0x00 then 0xFF, with the second start bit immediately after a one-bit stop -> two rxvalid pulses, exactly 10*CLKS_PER_BIT cycles apart, values 0x00 then 0xFF.
- Assert rst_n=0 during data bit 4 of a frame, release after 3 cycles -> outputs zero immediately (asynchronous); no strobe for the aborted frame. A subsequent 0x5A is received correctly.
- CLKS_PER_BIT=4 (minimum), random 256-byte stream with 1-bit stops -> every byte received in order, with no errors.
